lfsr_seq_ctrl: RTL and testbench
================================

LFSR_SEQ_CTRL -- requirements
Module: lfsr_seq_ctrl

Interface
REQ-001 Parameter SYM_DIV, default 4, clk cycles per LFSR symbol step (legal values 1..256).
REQ-002 Parameter CNT_W, default 23, width of the symbol counter (LFSR length + 1).
REQ-003 Port clk  in  1  single system clock; all logic is rising-edge.
REQ-004 Port reset_n  in  1  one clock; reset is asynchronous and active-low.
REQ-005 Port start  in  1  one-cycle request to begin a run; honoured only in IDLE.
REQ-006 Port abort  in  1  terminates an active run without a done pulse.
REQ-007 Port mode  in  1  0 = burst of burst_len symbols, 1 = run until the LFSR completes a full period.
REQ-008 Port burst_len  in  CNT_W  symbol count for burst mode.
REQ-009 Port cycle_in  in  1  sticky period-complete flag from the LFSR.
REQ-010 Port lfsr_rst  out  1  one-cycle pulse that returns the LFSR to its seed.
REQ-011 Port lfsr_clk_en  out  1  LFSR step enable at symbol rate.
REQ-012 Port acc_en  out  1  accumulator gate, co-timed with lfsr_clk_en.
REQ-013 Port busy  out  1  high in SEED and RUN.
REQ-014 Port done  out  1  one-cycle pulse on normal completion.
REQ-015 Port ovf  out  1  sticky; set when full-period mode saturates the counter.
REQ-016 Port sym_count  out  CNT_W  number of lfsr_clk_en pulses issued in the current or last run.

Function
REQ-017 FSM states: IDLE, SEED, RUN, DONE; all outputs registered.
REQ-018 IDLE: start=1 at edge k -> SEED during cycle k+1; mode and burst_len are captured at that edge; later changes are ignored until the next start.
REQ-019 SEED: lfsr_rst=1 for exactly one cycle; sym_count, divider, cycle_in edge detector and ovf cleared; then RUN, or DONE if burst mode with captured burst_len=0.
REQ-020 RUN: the divider counts 0..SYM_DIV-1 and wraps; lfsr_clk_en=acc_en=1 in the cycle where the divider equals SYM_DIV-1; first enable at cycle k+1+SYM_DIV; SYM_DIV=1 gives an enable every RUN cycle.
REQ-021 sym_count increments by 1 with every lfsr_clk_en and holds in IDLE and DONE.
REQ-022 Burst termination: the enable that brings sym_count to burst_len is the last one; the next cycle is DONE.
REQ-023 Full-period termination: a rising edge of cycle_in (registered compare) in RUN -> DONE next cycle; lfsr_clk_en is suppressed in the detection cycle.
REQ-024 Saturation: in full-period mode, sym_count reaching 2^CNT_W-1 sets ovf and forces DONE; sym_count never wraps.
REQ-025 DONE: done=1 for one cycle, busy=0, then IDLE.
REQ-026 abort=1 in SEED or RUN -> IDLE next cycle; no done pulse; sym_count holds; abort in IDLE or DONE has no effect.
REQ-027 abort and a terminal condition in the same cycle: abort wins.
REQ-028 start outside IDLE is ignored, including during the DONE cycle.

Reset
REQ-029 reset_n=0 asynchronously forces IDLE and sets lfsr_rst, lfsr_clk_en, acc_en, busy, done, ovf, sym_count and the divider to 0.
REQ-030 Reset mid-run discards the run; no done is issued after release.

Structure
REQ-031 The state encoding and the CNT_W default (LFSR length + 1) belong in the shared defines header.
REQ-032 The symbol-rate divider is a sub-module, sym_rate_div, with clear and tick output.

Verification
REQ-033 SYM_DIV=4, mode=0, burst_len=5, start at k -> lfsr_rst at k+1; enables at k+5, 9, 13, 17, 21; done at k+22; sym_count=5.
REQ-034 mode=0, burst_len=0 -> lfsr_rst at k+1, done at k+2, no enables, sym_count=0.
REQ-035 SYM_DIV=4, burst_len=10, abort after the 3rd enable -> busy=0 next cycle, no done, sym_count=3.
REQ-036 mode=1, cycle_in raised after the 7th enable -> done, sym_count=7, ovf=0, no further enables.
REQ-037 CNT_W=4, mode=1, cycle_in held 0 -> ovf=1, done, sym_count=15.
REQ-038 start pulsed during RUN is ignored; reset_n low mid-run -> all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/lfsr_seq_ctrl_pkg.sv
// Shared types and sizing for the LFSR sequence controller.
// Counter width is one bit wider than the LFSR it sequences.
package lfsr_seq_ctrl_pkg;

  localparam int LFSR_LEN  = 22;
  localparam int CNT_W_DEF = LFSR_LEN + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEED = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/lfsr_seq_ctrl_sym_rate_div.sv
// Symbol-rate divider: counts 0..SYM_DIV-1 and wraps.
// tick flags that the count after this edge is SYM_DIV-1.
module sym_rate_div #(
  parameter int SYM_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int DW = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(SYM_DIV - 1);

  logic [DW-1:0] cnt;
  logic [DW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clear)
      cnt_nxt = '0;
    else if (en)
      cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign tick = (cnt_nxt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else
      cnt <= cnt_nxt;
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer that seeds, steps and terminates an external LFSR.
// Every output is a register loaded from the next-state decode.
module lfsr_seq_ctrl
  import lfsr_seq_ctrl_pkg::*;
#(
  parameter int SYM_DIV = 4,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             cycle_in,
  output logic             lfsr_rst,
  output logic             lfsr_clk_en,
  output logic             acc_en,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [CNT_W-1:0] sym_count
);

  state_t           state;
  state_t           ns;
  logic             mode_q;
  logic [CNT_W-1:0] blen_q;
  logic             cyc_q;
  logic             tick;

  logic             burst_end;
  logic             per_end;
  logic             sat;

  logic             rst_d;
  logic             en_d;
  logic             busy_d;
  logic             done_d;
  logic             ovf_d;
  logic [CNT_W-1:0] cnt_d;

  sym_rate_div #(
    .SYM_DIV (SYM_DIV)
  ) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state == S_SEED),
    .en      (state == S_RUN),
    .tick    (tick)
  );

  assign burst_end = !mode_q && (sym_count == blen_q);
  assign per_end   = mode_q && cycle_in && !cyc_q;
  assign sat       = mode_q && (sym_count == '1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= ns;
  end

  always_comb begin
    ns = state;
    unique case (state)
      S_IDLE: if (start) ns = S_SEED;
      S_SEED: begin
        if (abort)
          ns = S_IDLE;
        else if (!mode_q && blen_q == '0)
          ns = S_DONE;
        else
          ns = S_RUN;
      end
      S_RUN: begin
        if (abort)
          ns = S_IDLE;
        else if (burst_end || per_end || sat)
          ns = S_DONE;
      end
      S_DONE: ns = S_IDLE;
    endcase
  end

  always_comb begin
    rst_d  = (ns == S_SEED);
    busy_d = (ns == S_SEED) || (ns == S_RUN);
    done_d = (ns == S_DONE);
    en_d   = (ns == S_RUN) && tick && (sym_count != '1);
    ovf_d  = ovf;
    cnt_d  = sym_count;
    if (ns == S_SEED) begin
      ovf_d = 1'b0;
      cnt_d = '0;
    end else begin
      if (state == S_RUN && !abort && sat)
        ovf_d = 1'b1;
      if (en_d)
        cnt_d = sym_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_rst    <= 1'b0;
      lfsr_clk_en <= 1'b0;
      acc_en      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ovf         <= 1'b0;
      sym_count   <= '0;
    end else begin
      lfsr_rst    <= rst_d;
      lfsr_clk_en <= en_d;
      acc_en      <= en_d;
      busy        <= busy_d;
      done        <= done_d;
      ovf         <= ovf_d;
      sym_count   <= cnt_d;
    end
  end

  // Run parameters are latched on the accepted start only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= 1'b0;
      blen_q <= '0;
      cyc_q  <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        mode_q <= mode;
        blen_q <= burst_len;
      end
      cyc_q <= (state == S_SEED) ? 1'b0 : cycle_in;
    end
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl: two instances, SYM_DIV=4/CNT_W=23
// and SYM_DIV=1/CNT_W=4, driven from shared stimulus.
module tb_lfsr_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mode = 1'b0;
  logic [22:0] blen = '0;
  logic        cyc = 1'b0;

  logic        rst0, en0, acc0, busy0, done0, ovf0;
  logic [22:0] cnt0;
  logic        rst1, en1, acc1, busy1, done1, ovf1;
  logic [3:0]  cnt1;

  logic [63:0] m_rst0, m_en0, m_acc0, m_busy0, m_done0;
  logic [63:0] m_rst1, m_en1, m_done1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lfsr_seq_ctrl #(.SYM_DIV(4), .CNT_W(23)) u0 (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .mode        (mode),
    .burst_len   (blen),
    .cycle_in    (cyc),
    .lfsr_rst    (rst0),
    .lfsr_clk_en (en0),
    .acc_en      (acc0),
    .busy        (busy0),
    .done        (done0),
    .ovf         (ovf0),
    .sym_count   (cnt0)
  );

  lfsr_seq_ctrl #(.SYM_DIV(1), .CNT_W(4)) u1 (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .mode        (mode),
    .burst_len   (blen[3:0]),
    .cycle_in    (cyc),
    .lfsr_rst    (rst1),
    .lfsr_clk_en (en1),
    .acc_en      (acc1),
    .busy        (busy1),
    .done        (done1),
    .ovf         (ovf1),
    .sym_count   (cnt1)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle c=1 is the one after the edge that samples start.
  // Inputs flip at c=1 to prove mode/burst_len are captured.
  task automatic obs(input int n, input int abort_at,
                     input int start_at, input int cyc_at);
    m_rst0 = '0; m_en0 = '0; m_acc0 = '0; m_busy0 = '0;
    m_done0 = '0; m_rst1 = '0; m_en1 = '0; m_done1 = '0;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      #1;
      start = (c == start_at);
      abort = (c == abort_at);
      cyc   = (cyc_at != 0) && (c >= cyc_at);
      if (c == 1) begin
        mode = ~mode;
        blen = '0;
      end
      m_rst0[c]  = rst0;
      m_en0[c]   = en0;
      m_acc0[c]  = acc0;
      m_busy0[c] = busy0;
      m_done0[c] = done0;
      m_rst1[c]  = rst1;
      m_en1[c]   = en1;
      m_done1[c] = done1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs0", {58'd0, rst0, en0, acc0, busy0, done0, ovf0}, 64'd0);
    chk("reset_cnt0", 64'(cnt0), 64'd0);
    chk("reset_outs1", {58'd0, rst1, en1, acc1, busy1, done1, ovf1}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // burst of 5
    start = 1'b1; mode = 1'b0; blen = 23'd5;
    obs(26, 0, 0, 0);
    chk("b5_rst0", m_rst0, 64'h2);
    chk("b5_en0", m_en0, 64'h222220);
    chk("b5_acc0", m_acc0, 64'h222220);
    chk("b5_done0", m_done0, 64'h400000);
    chk("b5_busy0", m_busy0, 64'h3FFFFE);
    chk("b5_cnt0", 64'(cnt0), 64'd5);
    chk("b5_en1", m_en1, 64'h7C);
    chk("b5_done1", m_done1, 64'h80);
    chk("b5_cnt1", 64'(cnt1), 64'd5);

    // zero-length burst
    start = 1'b1; mode = 1'b0; blen = 23'd0;
    obs(6, 0, 0, 0);
    chk("b0_rst0", m_rst0, 64'h2);
    chk("b0_en0", m_en0, 64'h0);
    chk("b0_done0", m_done0, 64'h4);
    chk("b0_busy0", m_busy0, 64'h2);
    chk("b0_cnt0", 64'(cnt0), 64'd0);
    chk("b0_rst1", m_rst1, 64'h2);
    chk("b0_done1", m_done1, 64'h4);
    chk("b0_cnt1", 64'(cnt1), 64'd0);

    // abort after third enable; u1 has already finished
    start = 1'b1; mode = 1'b0; blen = 23'd10;
    obs(30, 14, 0, 0);
    chk("ab_en0", m_en0, 64'h2220);
    chk("ab_done0", m_done0, 64'h0);
    chk("ab_busy0", m_busy0, 64'h7FFE);
    chk("ab_cnt0", 64'(cnt0), 64'd3);
    chk("ab_en1", m_en1, 64'hFFC);
    chk("ab_done1", m_done1, 64'h1000);
    chk("ab_cnt1", 64'(cnt1), 64'd10);

    // full period: u0 sees cycle_in after 7th enable, u1 saturates
    start = 1'b1; mode = 1'b1; blen = 23'd3;
    obs(36, 0, 7, 30);
    chk("fp_en0", m_en0, 64'h22222220);
    chk("fp_done0", m_done0, 64'h80000000);
    chk("fp_busy0", m_busy0, 64'h7FFFFFFE);
    chk("fp_cnt0", 64'(cnt0), 64'd7);
    chk("fp_ovf0", 64'(ovf0), 64'd0);
    chk("fp_en1", m_en1, 64'h1FFFC);
    chk("fp_done1", m_done1, 64'h20000);
    chk("fp_cnt1", 64'(cnt1), 64'd15);
    chk("fp_ovf1", 64'(ovf1), 64'd1);
    cyc = 1'b0;

    // reset mid-run
    start = 1'b1; mode = 1'b0; blen = 23'd10;
    obs(8, 0, 0, 0);
    chk("pre_rst_busy0", 64'(busy0), 64'd1);
    reset_n = 1'b0;
    #2;
    chk("mid_rst_outs0", {58'd0, rst0, en0, acc0, busy0, done0, ovf0}, 64'd0);
    chk("mid_rst_cnt0", 64'(cnt0), 64'd0);
    chk("mid_rst_outs1", {58'd0, rst1, en1, acc1, busy1, done1, ovf1}, 64'd0);
    chk("mid_rst_cnt1", 64'(cnt1), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    obs(30, 0, 0, 0);
    chk("post_rst_busy0", m_busy0, 64'h0);
    chk("post_rst_done0", m_done0, 64'h0);
    chk("post_rst_en0", m_en0, 64'h0);
    chk("post_rst_done1", m_done1, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
